// File: rtl/whac_pkg.sv
// Shared constants and helpers for the Whac-A-Mole game core.
package whac_pkg;

    // Board defaults shared by the spawner, button scanner and score blocks.
    localparam int DEF_NUM_HOLES = 18;
    localparam int DEF_NUM_MOLES = 3;

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Bits needed to hold a hole index; never narrower than one bit.
    function automatic int hole_w(input int num_holes);
        return (num_holes > 1) ? $clog2(num_holes) : 1;
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Shared 16-bit Galois LFSR used as the mole position source.
module mole_lfsr
    import whac_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] state_o
);

    // An all-zero state would lock the register, so a zero seed becomes 1.
    localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] state_q;
    logic [15:0] state_d;

    // One Galois step: shift right, fold the dropped bit back through the taps.
    always_comb begin
        state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? LFSR_TAPS : 16'h0000);
    end

    // State register; free-running, advances every cycle out of reset.
    always_ff @(posedge clk) begin
        if (reset) state_q <= SEED_NZ;
        else       state_q <= state_d;
    end

    assign state_o = state_q;

endmodule

// File: rtl/mole_spawner.sv
// Slot-based mole generator: spawns moles at distinct random holes, ages them,
// and scores whacks and expiries.
module mole_spawner
    import whac_pkg::*;
#(
    parameter int          NUM_MOLES = DEF_NUM_MOLES,
    parameter int          NUM_HOLES = DEF_NUM_HOLES,
    parameter int          LIFE_W    = 24,
    parameter int          CNT_W     = 16,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           mole_clk,
    input  logic [LIFE_W-1:0]              lifetime,
    input  logic [NUM_HOLES-1:0]           whack,
    output logic [NUM_HOLES-1:0]           mole_positions,
    output logic [$clog2(NUM_MOLES+1)-1:0] mole_count,
    output logic                           hit,
    output logic                           miss,
    output logic [CNT_W-1:0]               hit_count,
    output logic [CNT_W-1:0]               miss_count
);

    localparam int HOLE_W = hole_w(NUM_HOLES);
    localparam int MC_W   = $clog2(NUM_MOLES + 1);
    localparam int SUM_W  = CNT_W + MC_W;

    typedef struct packed {
        logic              live;
        logic              pend;
        logic [HOLE_W-1:0] pos;
        logic [LIFE_W-1:0] life;
    } mole_slot_t;

    if (NUM_MOLES > NUM_HOLES) begin : g_bad_cfg
        $error("mole_spawner: NUM_MOLES must not exceed NUM_HOLES");
    end

    logic [15:0]          lfsr_state;
    logic                 prev_q;
    logic                 tick;
    logic [HOLE_W-1:0]    cand;
    logic [NUM_HOLES-1:0] occ_map;
    logic                 cand_busy;
    logic [LIFE_W-1:0]    life_load;
    logic [NUM_MOLES-1:0] spawn_sel;

    logic [NUM_MOLES-1:0] live_q_v;
    logic [NUM_MOLES-1:0] pend_q_v;
    logic [NUM_MOLES-1:0] live_d_v;
    logic [NUM_MOLES-1:0] hit_v;
    logic [NUM_MOLES-1:0] exp_v;
    logic [HOLE_W-1:0]    pos_q_v [NUM_MOLES];
    logic [HOLE_W-1:0]    pos_d_v [NUM_MOLES];

    logic [NUM_HOLES-1:0] map_q, map_d;
    logic [MC_W-1:0]      count_q, count_d;
    logic                 hit_q, miss_q;
    logic [CNT_W-1:0]     hc_q, hc_d;
    logic [CNT_W-1:0]     mc_q, mc_d;
    logic [MC_W-1:0]      n_hit, n_exp;
    logic [SUM_W-1:0]     hc_sum, mc_sum;

    mole_lfsr #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .state_o (lfsr_state)
    );

    assign tick      = enable && mole_clk && !prev_q;
    assign cand      = HOLE_W'(lfsr_state % 16'(NUM_HOLES));
    assign life_load = (lifetime == '0) ? LIFE_W'(1) : lifetime;

    // Holes currently held by live slots; a candidate is refused if taken or being pressed.
    always_comb begin
        occ_map = '0;
        for (int i = 0; i < NUM_MOLES; i++) begin
            if (live_q_v[i]) occ_map[pos_q_v[i]] = 1'b1;
        end
        cand_busy = occ_map[cand] | whack[cand];
    end

    // Priority encoder: only the lowest-index pending slot may try the candidate.
    always_comb begin
        logic found;
        found     = 1'b0;
        spawn_sel = '0;
        for (int i = 0; i < NUM_MOLES; i++) begin
            if (!found && pend_q_v[i] && !live_q_v[i]) begin
                found = 1'b1;
                if (enable && !cand_busy) spawn_sel[i] = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_MOLES; i++) begin : g_slot
        mole_slot_t s_q, s_d;
        logic       hit_s, exp_s;

        // Slot next state: a hit beats expiry; a freed slot only re-arms on a later tick.
        always_comb begin
            s_d   = s_q;
            hit_s = 1'b0;
            exp_s = 1'b0;
            if (enable) begin
                if (s_q.live) begin
                    if (whack[s_q.pos]) begin
                        s_d.live = 1'b0;
                        hit_s    = 1'b1;
                    end else if (s_q.life == LIFE_W'(1)) begin
                        s_d.live = 1'b0;
                        exp_s    = 1'b1;
                    end else begin
                        s_d.life = s_q.life - LIFE_W'(1);
                    end
                end else if (spawn_sel[i]) begin
                    s_d.live = 1'b1;
                    s_d.pend = 1'b0;
                    s_d.pos  = cand;
                    s_d.life = life_load;
                end else if (tick) begin
                    s_d.pend = 1'b1;
                end
            end else begin
                s_d.pend = 1'b0;
            end
        end

        // Slot register.
        always_ff @(posedge clk) begin
            if (reset) s_q <= '0;
            else       s_q <= s_d;
        end

        assign live_q_v[i] = s_q.live;
        assign pend_q_v[i] = s_q.pend;
        assign pos_q_v[i]  = s_q.pos;
        assign live_d_v[i] = s_d.live;
        assign pos_d_v[i]  = s_d.pos;
        assign hit_v[i]    = hit_s;
        assign exp_v[i]    = exp_s;
    end

    // Next hole map and live count, registered alongside the slots so they never disagree.
    always_comb begin
        map_d   = '0;
        count_d = '0;
        for (int i = 0; i < NUM_MOLES; i++) begin
            if (live_d_v[i]) begin
                map_d[pos_d_v[i]] = 1'b1;
                count_d           = count_d + MC_W'(1);
            end
        end
    end

    // Saturating score counters; several slots can resolve in the same cycle.
    always_comb begin
        n_hit = '0;
        n_exp = '0;
        for (int i = 0; i < NUM_MOLES; i++) begin
            n_hit = n_hit + MC_W'(hit_v[i]);
            n_exp = n_exp + MC_W'(exp_v[i]);
        end
        hc_sum = SUM_W'(hc_q) + SUM_W'(n_hit);
        mc_sum = SUM_W'(mc_q) + SUM_W'(n_exp);
        hc_d   = (hc_sum > SUM_W'({CNT_W{1'b1}})) ? '1 : hc_sum[CNT_W-1:0];
        mc_d   = (mc_sum > SUM_W'({CNT_W{1'b1}})) ? '1 : mc_sum[CNT_W-1:0];
    end

    // Output and edge-detect registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q  <= 1'b0;
            map_q   <= '0;
            count_q <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            hc_q    <= '0;
            mc_q    <= '0;
        end else begin
            prev_q  <= mole_clk;
            map_q   <= map_d;
            count_q <= count_d;
            hit_q   <= |hit_v;
            miss_q  <= |exp_v;
            hc_q    <= hc_d;
            mc_q    <= mc_d;
        end
    end

    assign mole_positions = map_q;
    assign mole_count     = count_q;
    assign hit            = hit_q;
    assign miss           = miss_q;
    assign hit_count      = hc_q;
    assign miss_count     = mc_q;

endmodule

// File: tb/tb_mole_spawner.sv
// Directed bench for mole_spawner: a 4-hole/2-mole board and a 2-hole/2-mole
// board with 2-bit counters for the saturation and stress runs.
module tb_mole_spawner;

    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // board A
    logic        a_reset, a_en, a_mclk;
    logic [7:0]  a_life;
    logic [3:0]  a_whack, a_pos;
    logic [1:0]  a_cnt;
    logic        a_hit, a_miss;
    logic [15:0] a_hc, a_mc;

    // board B
    logic        b_reset, b_en, b_mclk;
    logic [7:0]  b_life;
    logic [1:0]  b_whack, b_pos;
    logic [1:0]  b_cnt;
    logic        b_hit, b_miss;
    logic [1:0]  b_hc, b_mc;

    mole_spawner #(.NUM_MOLES(2), .NUM_HOLES(4), .LIFE_W(8), .CNT_W(16), .SEED(SEED)) dut_a (
        .clk(clk), .reset(a_reset), .enable(a_en), .mole_clk(a_mclk), .lifetime(a_life),
        .whack(a_whack), .mole_positions(a_pos), .mole_count(a_cnt), .hit(a_hit),
        .miss(a_miss), .hit_count(a_hc), .miss_count(a_mc)
    );

    mole_spawner #(.NUM_MOLES(2), .NUM_HOLES(2), .LIFE_W(8), .CNT_W(2), .SEED(SEED)) dut_b (
        .clk(clk), .reset(b_reset), .enable(b_en), .mole_clk(b_mclk), .lifetime(b_life),
        .whack(b_whack), .mole_positions(b_pos), .mole_count(b_cnt), .hit(b_hit),
        .miss(b_miss), .hit_count(b_hc), .miss_count(b_mc)
    );

    // Reference LFSR for board A; lfsr_used is the value seen during the previous cycle.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    logic [15:0] m_lfsr = 16'h0;
    logic [15:0] lfsr_used = 16'h0;
    always @(posedge clk) begin
        lfsr_used <= m_lfsr;
        m_lfsr    <= a_reset ? SEED : lfsr_step(m_lfsr);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int pc4(input logic [3:0] v);
        int n = 0;
        for (int i = 0; i < 4; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic int low_set(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic int low_clr(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (!v[i]) return i;
        return 0;
    endfunction

    typedef struct {
        logic        rst, en, mclk;
        logic [3:0]  wh;
        logic [3:0]  pos;
        logic [1:0]  cnt;
        logic        hit, miss;
        logic [15:0] hc, mc;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int t_a, t_b, m1, m2, h, e, nz, bad_x, bad_dup, bad_cnt, saw2;
        logic [3:0] exp_pos, keep;

        // rst en mclk whack | pos cnt hit miss hc mc
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 16'd0, 16'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 16'd0, 16'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 16'd0, 16'd0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 16'd0, 16'd0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 16'd0, 16'd0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 16'd0, 16'd0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 4'hF, 4'h0, 2'd0, 1'b0, 1'b0, 16'd0, 16'd0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 16'd0, 16'd0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 16'd0, 16'd0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 2'd0, 1'b0, 1'b0, 16'd0, 16'd0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 16'd0, 16'd0};

        a_life = 8'd10; b_life = 8'd3;
        b_reset = 1'b1; b_en = 1'b0; b_mclk = 1'b0; b_whack = 2'b00;

        // 1. reset, disabled ticks, held level, empty-hole whacks
        for (int i = 0; i < 11; i++) begin
            a_reset = tbl[i].rst; a_en = tbl[i].en; a_mclk = tbl[i].mclk; a_whack = tbl[i].wh;
            if (i == 3) b_reset = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d {pos,cnt,hit,miss,hc,mc}", i),
                {a_pos, a_cnt, a_hit, a_miss, a_hc, a_mc},
                {tbl[i].pos, tbl[i].cnt, tbl[i].hit, tbl[i].miss, tbl[i].hc, tbl[i].mc});
        end

        // 2. one tick fills both slots at distinct holes; both expire after 10 cycles
        a_life = 8'd10; a_mclk = 1'b1;
        @(negedge clk);
        chk("t2_no_mole_yet", a_cnt, 2'd0);
        @(negedge clk);
        exp_pos = 4'b0001 << (lfsr_used % 16'd4);
        chk("t2_first_count", a_cnt, 2'd1);
        chk("t2_first_pos", a_pos, exp_pos);
        t_a = cyc; t_b = -1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (a_cnt == 2'd2 && t_b < 0) t_b = cyc;
        end
        chk("t2_two_live", a_cnt, 2'd2);
        chk("t2_distinct", pc4(a_pos), 2);
        m1 = -1; m2 = -1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (a_miss) begin
                if (m1 < 0) m1 = cyc; else if (m2 < 0) m2 = cyc;
            end
        end
        chk("t2_expiry0_cycle", m1, t_a + 10);
        chk("t2_expiry1_cycle", m2, t_b + 10);
        chk("t2_miss_count", a_mc, 16'd2);
        chk("t2_all_gone", a_cnt, 2'd0);
        chk("t2_hit_count", a_hc, 16'd0);

        // 3. whack a live mole, then an empty hole
        a_mclk = 1'b0; a_life = 8'd50;
        @(negedge clk);
        a_mclk = 1'b1;
        for (int k = 0; k < 8 && a_cnt != 2'd2; k++) @(negedge clk);
        chk("t3_two_live", a_cnt, 2'd2);
        h = low_set(a_pos); keep = a_pos;
        a_whack = 4'b0001 << h;
        @(negedge clk);
        a_whack = 4'h0;
        chk("t3_bit_cleared", a_pos[h], 1'b0);
        chk("t3_other_kept", a_pos, keep & ~(4'b0001 << h));
        chk("t3_hit_pulse", {a_hit, a_miss}, 2'b10);
        chk("t3_hit_count", a_hc, 16'd1);
        chk("t3_count", a_cnt, 2'd1);
        @(negedge clk);
        chk("t3_hit_one_cycle", a_hit, 1'b0);
        e = low_clr(a_pos); keep = a_pos;
        a_whack = 4'b0001 << e;
        @(negedge clk);
        a_whack = 4'h0;
        chk("t3_empty_no_hit", a_hit, 1'b0);
        chk("t3_empty_counts", {a_hc, a_mc}, {16'd1, 16'd2});
        chk("t3_empty_board", a_pos, keep);

        // 4. whack in the expiry cycle: hit wins, no miss
        a_whack = 4'b0001 << low_set(a_pos);
        @(negedge clk);
        a_whack = 4'h0;
        chk("t4_clear_board", {a_cnt, a_hc}, {2'd0, 16'd2});
        a_mclk = 1'b0; a_life = 8'd4;
        @(negedge clk);
        a_mclk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t4_spawn", a_cnt, 2'd1);
        h = low_set(a_pos);
        repeat (3) @(negedge clk);
        a_whack = 4'b0001 << h;
        @(negedge clk);
        a_whack = 4'h0;
        chk("t4_hit_not_miss", {a_hit, a_miss}, 2'b10);
        chk("t4_counts", {a_hc, a_mc}, {16'd2 + 16'd1, 16'd2});
        for (int k = 0; k < 12 && a_cnt != 2'd0; k++) @(negedge clk);
        @(negedge clk);
        chk("t4_second_expired", {a_cnt, a_hc, a_mc}, {2'd0, 16'd3, 16'd3});

        // 6. reset with one mole live and one spawn held pending
        a_mclk = 1'b0; a_life = 8'd50;
        @(negedge clk);
        a_mclk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        a_whack = ~a_pos;
        repeat (3) @(negedge clk);
        chk("t6_pending_blocked", a_cnt, 2'd1);
        a_mclk = 1'b0; a_reset = 1'b1;
        @(negedge clk);
        chk("t6_reset_outputs", {a_pos, a_cnt, a_hit, a_miss, a_hc, a_mc}, 40'h0);
        a_reset = 1'b0; a_whack = 4'h0;
        nz = 0;
        repeat (5) begin
            @(negedge clk);
            if (a_cnt != 2'd0 || a_pos != 4'h0) nz++;
        end
        chk("t6_no_spawn_after_reset", nz, 0);
        a_mclk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t6_new_tick_spawns", a_cnt, 2'd1);

        // 5. two-hole stress run, then hit-count saturation
        b_en = 1'b1; b_life = 8'd3;
        bad_x = 0; bad_dup = 0; bad_cnt = 0; saw2 = 0;
        for (int t = 0; t < 1000; t++) begin
            for (int p = 0; p < 4; p++) begin
                b_mclk = (p < 2);
                @(negedge clk);
                if ($isunknown({b_pos, b_cnt, b_hit, b_miss, b_hc, b_mc})) bad_x++;
                if (int'(b_pos[0]) + int'(b_pos[1]) != int'(b_cnt)) bad_dup++;
                if (b_cnt > 2'd2) bad_cnt++;
                if (b_cnt == 2'd2) saw2 = 1;
            end
        end
        chk("t5_no_x", bad_x, 0);
        chk("t5_no_duplicates", bad_dup, 0);
        chk("t5_count_bound", bad_cnt, 0);
        chk("t5_both_slots_used", saw2, 1);
        chk("t5_miss_saturated", b_mc, 2'd3);
        chk("t5_no_hits", b_hc, 2'd0);
        b_life = 8'd200;
        for (int n = 1; n <= 5; n++) begin
            b_mclk = 1'b0;
            @(negedge clk);
            b_mclk = 1'b1;
            for (int k = 0; k < 10 && b_cnt == 2'd0; k++) @(negedge clk);
            b_whack = b_pos[0] ? 2'b01 : 2'b10;
            @(negedge clk);
            b_whack = 2'b00;
            chk($sformatf("t5_hit_count_%0d", n), b_hc, (n < 3) ? 2'(n) : 2'd3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
